// File: rtl/receiver3b.sv
// Three-frame serial receiver: assembles 8N1 frames (MSB first) into one 24-bit word.
// Words abort on a bad stop bit or an over-long gap between frames; the partial word is dropped.
module receiver3b #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int GAP_BITS     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [23:0] data,
  output logic        data_valid,
  output logic        framing_error,
  output logic        timeout_error,
  output logic        busy,
  output logic [2:0]  state_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0] GAP_M1  = 32'(GAP_BITS * CLKS_PER_BIT - 1);

  logic        r_sync1, r_sync2;
  state_t      r_state;
  logic [15:0] r_baud;
  logic [31:0] r_gap;
  logic [2:0]  r_bit;
  logic [1:0]  r_frame;
  logic        r_from_gap;
  logic [23:0] r_shift;
  logic [23:0] r_data;
  logic        r_dv, r_fe, r_te;

  state_t      w_state;
  logic [15:0] w_baud;
  logic [31:0] w_gap;
  logic [2:0]  w_bit;
  logic [1:0]  w_frame;
  logic        w_from_gap;
  logic [23:0] w_shift;
  logic [23:0] w_data;
  logic        w_dv, w_fe, w_te;
  logic        w_rx_s;

  assign w_rx_s = r_sync2;

  always_comb begin
    w_state    = r_state;
    w_baud     = r_baud;
    w_gap      = r_gap;
    w_bit      = r_bit;
    w_frame    = r_frame;
    w_from_gap = r_from_gap;
    w_shift    = r_shift;
    w_data     = r_data;
    w_dv       = 1'b0;
    w_fe       = 1'b0;
    w_te       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state    = S_START;
          w_bit      = 3'd0;
          w_baud     = HALF_M1;
          w_from_gap = 1'b0;
        end
      end
      S_START: begin
        if (r_baud != 16'd0) begin
          w_baud = r_baud - 16'd1;
        end else if (!w_rx_s) begin
          w_state = S_DATA;
          w_baud  = FULL_M1;
        end else begin
          // Start bit vanished by mid-bit: a glitch, resume where the frame began.
          w_state = r_from_gap ? S_GAP : S_IDLE;
        end
      end
      S_DATA: begin
        if (r_baud != 16'd0) begin
          w_baud = r_baud - 16'd1;
        end else begin
          w_shift = {r_shift[22:0], w_rx_s};
          w_baud  = FULL_M1;
          w_bit   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state = S_STOP;
        end
      end
      S_STOP: begin
        if (r_baud != 16'd0) begin
          w_baud = r_baud - 16'd1;
        end else if (w_rx_s) begin
          if (r_frame == 2'd2) begin
            w_data  = r_shift;
            w_dv    = 1'b1;
            w_frame = 2'd0;
            w_state = S_IDLE;
          end else begin
            w_frame = r_frame + 2'd1;
            w_gap   = GAP_M1;
            w_state = S_GAP;
          end
        end else begin
          w_fe    = 1'b1;
          w_frame = 2'd0;
          w_shift = 24'h000000;
          w_state = S_IDLE;
        end
      end
      S_GAP: begin
        if (!w_rx_s) begin
          w_state    = S_START;
          w_bit      = 3'd0;
          w_baud     = HALF_M1;
          w_from_gap = 1'b1;
        end else if (r_gap == 32'd0) begin
          w_te    = 1'b1;
          w_frame = 2'd0;
          w_shift = 24'h000000;
          w_state = S_IDLE;
        end else begin
          w_gap = r_gap - 32'd1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_state    <= S_IDLE;
      r_baud     <= 16'd0;
      r_gap      <= 32'd0;
      r_bit      <= 3'd0;
      r_frame    <= 2'd0;
      r_from_gap <= 1'b0;
      r_shift    <= 24'h000000;
      r_data     <= 24'h000000;
      r_dv       <= 1'b0;
      r_fe       <= 1'b0;
      r_te       <= 1'b0;
    end else begin
      r_sync1    <= rx;
      r_sync2    <= r_sync1;
      r_state    <= w_state;
      r_baud     <= w_baud;
      r_gap      <= w_gap;
      r_bit      <= w_bit;
      r_frame    <= w_frame;
      r_from_gap <= w_from_gap;
      r_shift    <= w_shift;
      r_data     <= w_data;
      r_dv       <= w_dv;
      r_fe       <= w_fe;
      r_te       <= w_te;
    end
  end

  assign data          = r_data;
  assign data_valid    = r_dv;
  assign framing_error = r_fe;
  assign timeout_error = r_te;
  assign busy          = (r_state != S_IDLE);
  assign state_out     = r_state;

endmodule

// File: tb/tb_receiver3b.sv
// Directed bench for receiver3b: expected words queued at stimulus time, popped on data_valid.
module tb_receiver3b;

  localparam int CPB = 8;
  localparam int GB  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic [23:0] data;
  logic        data_valid, framing_error, timeout_error, busy;
  logic [2:0]  state_out;

  int n_cmp = 0;
  int n_err = 0;
  int n_dv = 0;
  int n_fe = 0;
  int n_te = 0;
  int n_gap_cyc = 0;
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  receiver3b #(.CLKS_PER_BIT(CPB), .GAP_BITS(GB)) dut (
    .clk(clk), .reset(reset), .rx(rx), .data(data), .data_valid(data_valid),
    .framing_error(framing_error), .timeout_error(timeout_error),
    .busy(busy), .state_out(state_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (state_out == 3'd4) n_gap_cyc++;
    if (data_valid || framing_error || timeout_error)
      check("one_pulse_at_a_time",
            32'(int'(data_valid) + int'(framing_error) + int'(timeout_error)), 32'd1);
    if (data_valid) begin
      n_dv++;
      if (exp_q.size() == 0) check("dv_with_empty_scoreboard", 32'(exp_q.size()), 32'd1);
      else check("scoreboard_data", {8'h00, data}, {8'h00, exp_q.pop_front()});
    end
    if (framing_error) n_fe++;
    if (timeout_error) n_te++;
  end

  task automatic bit_period(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    bit_period(1'b0);
    for (int i = 7; i >= 0; i--) bit_period(b[i]);
    bit_period(stop_v);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int dv0, fe0, te0;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_data", {8'h00, data}, 32'h0);
    check("rst_dv", {31'b0, data_valid}, 32'd0);
    check("rst_fe", {31'b0, framing_error}, 32'd0);
    check("rst_te", {31'b0, timeout_error}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_state", {29'b0, state_out}, 32'd0);
    reset = 1'b0;
    idle(20);

    // Back-to-back word
    dv0 = n_dv; fe0 = n_fe; te0 = n_te;
    exp_q.push_back(24'hA53C0F);
    send_byte(8'hA5, 1'b1);
    check("gap_state_after_frame1", {29'b0, state_out}, 32'd4);
    check("busy_in_gap", {31'b0, busy}, 32'd1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h0F, 1'b1);
    idle(16);
    check("w1_data", {8'h00, data}, 32'hA53C0F);
    check("w1_dv_count", 32'(n_dv - dv0), 32'd1);
    check("w1_fe_count", 32'(n_fe - fe0), 32'd0);
    check("w1_te_count", 32'(n_te - te0), 32'd0);
    check("w1_state_idle", {29'b0, state_out}, 32'd0);

    // Short low glitch on idle line
    dv0 = n_dv; fe0 = n_fe; te0 = n_te;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    idle(20);
    check("glitch_state", {29'b0, state_out}, 32'd0);
    check("glitch_pulses", 32'(n_dv - dv0 + n_fe - fe0 + n_te - te0), 32'd0);
    check("glitch_data", {8'h00, data}, 32'hA53C0F);

    // Bad stop bit in frame 2, then a good word
    dv0 = n_dv; fe0 = n_fe; te0 = n_te;
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b0);
    idle(24);
    check("fe_count", 32'(n_fe - fe0), 32'd1);
    check("fe_no_dv", 32'(n_dv - dv0), 32'd0);
    check("fe_no_te", 32'(n_te - te0), 32'd0);
    check("fe_data_held", {8'h00, data}, 32'hA53C0F);
    check("fe_state", {29'b0, state_out}, 32'd0);
    dv0 = n_dv; fe0 = n_fe;
    exp_q.push_back(24'h123456);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    idle(16);
    check("w2_data", {8'h00, data}, 32'h123456);
    check("w2_dv_count", 32'(n_dv - dv0), 32'd1);
    check("w2_fe_count", 32'(n_fe - fe0), 32'd0);

    // Inter-frame timeout
    dv0 = n_dv; fe0 = n_fe; te0 = n_te;
    n_gap_cyc = 0;
    send_byte(8'h11, 1'b1);
    idle(40);
    check("to_count", 32'(n_te - te0), 32'd1);
    check("to_gap_cycles", 32'(n_gap_cyc), 32'(GB * CPB));
    check("to_state", {29'b0, state_out}, 32'd0);
    check("to_data_held", {8'h00, data}, 32'h123456);
    check("to_other_pulses", 32'(n_dv - dv0 + n_fe - fe0), 32'd0);

    // Reset during frame 3
    dv0 = n_dv; fe0 = n_fe; te0 = n_te;
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    bit_period(1'b0);
    bit_period(1'b1);
    bit_period(1'b0);
    bit_period(1'b1);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_state", {29'b0, state_out}, 32'd0);
    reset = 1'b0;
    idle(20);
    check("midrst_data", {8'h00, data}, 32'h0);
    check("midrst_pulses", 32'(n_dv - dv0 + n_fe - fe0 + n_te - te0), 32'd0);
    dv0 = n_dv;
    exp_q.push_back(24'hFFFFFF);
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(16);
    check("w3_data", {8'h00, data}, 32'hFFFFFF);
    check("w3_dv_count", 32'(n_dv - dv0), 32'd1);

    // Three-bit gaps between frames stay inside the timeout window
    dv0 = n_dv; fe0 = n_fe; te0 = n_te;
    exp_q.push_back(24'h008001);
    send_byte(8'h00, 1'b1);
    idle(3 * CPB);
    send_byte(8'h80, 1'b1);
    idle(3 * CPB);
    send_byte(8'h01, 1'b1);
    idle(16);
    check("w4_data", {8'h00, data}, 32'h008001);
    check("w4_dv_count", 32'(n_dv - dv0), 32'd1);
    check("w4_no_te", 32'(n_te - te0), 32'd0);
    check("w4_no_fe", 32'(n_fe - fe0), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
